// File: rtl/stopwatch_core_if.sv
// Stopwatch core I/O bundle: divider levels, user controls in;
// BCD digits, run flag, blanking and rollover out.
interface stopwatch_core_if;
  logic       CLK_1HZ;
  logic       CLK_2HZ;
  logic       BTN_PAUSE;
  logic       ADJ;
  logic       SEL;
  logic [3:0] MIN_TENS;
  logic [3:0] MIN_ONES;
  logic [3:0] SEC_TENS;
  logic [3:0] SEC_ONES;
  logic       RUNNING;
  logic       BLANK_MIN;
  logic       BLANK_SEC;
  logic       ROLLOVER;

  modport master (
    output CLK_1HZ, CLK_2HZ, BTN_PAUSE, ADJ, SEL,
    input  MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES,
    input  RUNNING, BLANK_MIN, BLANK_SEC, ROLLOVER
  );

  modport slave (
    input  CLK_1HZ, CLK_2HZ, BTN_PAUSE, ADJ, SEL,
    output MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES,
    output RUNNING, BLANK_MIN, BLANK_SEC, ROLLOVER
  );
endinterface

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch: edge-detects divider levels into ticks,
// run/pause/adjust FSM, blink blanking. Ports: CLK_REF, CLK_RES, bus.
module stopwatch_core #(
  parameter int MAX_MIN = 99
) (
  input logic       CLK_REF,
  input logic       CLK_RES,
  stopwatch_core_if.slave bus
);

  localparam logic [1:0] PAUSED = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] ADJUST = 2'd2;

  localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_MIN % 10);

  logic [1:0] state, state_nx;
  logic       hist_1hz, hist_2hz;
  logic       tick_1hz, tick_2hz;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [3:0] min_tens_nx, min_ones_nx, sec_tens_nx, sec_ones_nx;
  logic [3:0] min_inc_t, min_inc_o, sec_inc_t, sec_inc_o;
  logic       sec_max, min_max;
  logic       roll, roll_nx;

  assign tick_1hz = bus.CLK_1HZ & ~hist_1hz;
  assign tick_2hz = bus.CLK_2HZ & ~hist_2hz;

  assign sec_max = (sec_tens == 4'd5) && (sec_ones == 4'd9);
  assign min_max = (min_tens == MAX_T) && (min_ones == MAX_O);

  // Wrapping field increments, shared by run and adjust paths
  always_comb begin
    sec_inc_t = sec_tens;
    sec_inc_o = sec_ones + 4'd1;
    if (sec_max) begin
      sec_inc_t = 4'd0;
      sec_inc_o = 4'd0;
    end else if (sec_ones == 4'd9) begin
      sec_inc_t = sec_tens + 4'd1;
      sec_inc_o = 4'd0;
    end
  end

  always_comb begin
    min_inc_t = min_tens;
    min_inc_o = min_ones + 4'd1;
    if (min_max) begin
      min_inc_t = 4'd0;
      min_inc_o = 4'd0;
    end else if (min_ones == 4'd9) begin
      min_inc_t = min_tens + 4'd1;
      min_inc_o = 4'd0;
    end
  end

  always_comb begin
    state_nx    = state;
    min_tens_nx = min_tens;
    min_ones_nx = min_ones;
    sec_tens_nx = sec_tens;
    sec_ones_nx = sec_ones;
    roll_nx     = 1'b0;
    unique case (1'b1)
      (state == PAUSED): begin
        if (bus.ADJ)
          state_nx = ADJUST;
        else if (bus.BTN_PAUSE)
          state_nx = RUN;
      end
      (state == RUN): begin
        if (bus.ADJ) begin
          state_nx = ADJUST;
        end else begin
          if (tick_1hz) begin
            sec_tens_nx = sec_inc_t;
            sec_ones_nx = sec_inc_o;
            if (sec_max) begin
              min_tens_nx = min_inc_t;
              min_ones_nx = min_inc_o;
              roll_nx     = min_max;
            end
          end
          if (bus.BTN_PAUSE)
            state_nx = PAUSED;
        end
      end
      (state == ADJUST): begin
        if (tick_2hz) begin
          if (bus.SEL) begin
            sec_tens_nx = sec_inc_t;
            sec_ones_nx = sec_inc_o;
          end else begin
            min_tens_nx = min_inc_t;
            min_ones_nx = min_inc_o;
          end
        end
        if (!bus.ADJ)
          state_nx = PAUSED;
      end
      default: state_nx = PAUSED;
    endcase
  end

  // History regs reset high: a level already high at release is no edge
  always_ff @(posedge CLK_REF or posedge CLK_RES) begin
    if (CLK_RES) begin
      state    <= PAUSED;
      hist_1hz <= 1'b1;
      hist_2hz <= 1'b1;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      roll     <= 1'b0;
    end else begin
      state    <= state_nx;
      hist_1hz <= bus.CLK_1HZ;
      hist_2hz <= bus.CLK_2HZ;
      min_tens <= min_tens_nx;
      min_ones <= min_ones_nx;
      sec_tens <= sec_tens_nx;
      sec_ones <= sec_ones_nx;
      roll     <= roll_nx;
    end
  end

  assign bus.MIN_TENS  = min_tens;
  assign bus.MIN_ONES  = min_ones;
  assign bus.SEC_TENS  = sec_tens;
  assign bus.SEC_ONES  = sec_ones;
  assign bus.RUNNING   = (state == RUN);
  assign bus.ROLLOVER  = roll;
  assign bus.BLANK_MIN = (state == ADJUST) & ~bus.SEL & bus.CLK_2HZ;
  assign bus.BLANK_SEC = (state == ADJUST) & bus.SEL & bus.CLK_2HZ;

  a_legal: assert property (
    @(posedge CLK_REF) disable iff (CLK_RES)
      sec_tens <= 4'd5 && sec_ones <= 4'd9 && min_ones <= 4'd9 &&
      (int'(min_tens) * 10 + int'(min_ones)) <= MAX_MIN
  );

endmodule

// File: tb/tb_stopwatch_core.sv
// Stopwatch core bench: two instances (MAX_MIN 99 and 2) share stimulus
// and are compared each cycle against a seconds-arithmetic model.
module tb_stopwatch_core;

  localparam int S_P = 0;
  localparam int S_R = 1;
  localparam int S_A = 2;

  typedef struct {
    int mins;
    int secs;
    int st;
    bit roll;
    int maxm;
  } mdl_t;

  typedef struct {
    logic c1, c2, btn, adj, sel;
    int   em, es;
    logic er, ebm, ebs;
  } vec_t;

  logic clk, rst;
  logic c1, c2, btn, adj, sel;
  logic [19:0] got_a, got_b;
  int checks, errors;
  mdl_t m[2];
  bit p1, p2;
  vec_t tv[18];

  stopwatch_core_if ia();
  stopwatch_core_if ib();

  assign ia.CLK_1HZ = c1;
  assign ia.CLK_2HZ = c2;
  assign ia.BTN_PAUSE = btn;
  assign ia.ADJ = adj;
  assign ia.SEL = sel;
  assign ib.CLK_1HZ = c1;
  assign ib.CLK_2HZ = c2;
  assign ib.BTN_PAUSE = btn;
  assign ib.ADJ = adj;
  assign ib.SEL = sel;

  assign got_a = {ia.MIN_TENS, ia.MIN_ONES, ia.SEC_TENS, ia.SEC_ONES,
                  ia.RUNNING, ia.ROLLOVER, ia.BLANK_MIN, ia.BLANK_SEC};
  assign got_b = {ib.MIN_TENS, ib.MIN_ONES, ib.SEC_TENS, ib.SEC_ONES,
                  ib.RUNNING, ib.ROLLOVER, ib.BLANK_MIN, ib.BLANK_SEC};

  stopwatch_core #(.MAX_MIN(99)) dut_a (
    .CLK_REF(clk), .CLK_RES(rst), .bus(ia)
  );
  stopwatch_core #(.MAX_MIN(2)) dut_b (
    .CLK_REF(clk), .CLK_RES(rst), .bus(ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mdl_t nxt(mdl_t x, bit t1, bit t2);
    mdl_t y;
    int tot;
    y = x;
    y.roll = 1'b0;
    case (x.st)
      S_P: begin
        if (adj) y.st = S_A;
        else if (btn) y.st = S_R;
      end
      S_R: begin
        if (adj) begin
          y.st = S_A;
        end else begin
          if (t1) begin
            tot = x.mins * 60 + x.secs + 1;
            if (tot == (x.maxm + 1) * 60) begin
              tot = 0;
              y.roll = 1'b1;
            end
            y.mins = tot / 60;
            y.secs = tot % 60;
          end
          if (btn) y.st = S_P;
        end
      end
      default: begin
        if (t2) begin
          if (sel) y.secs = (x.secs + 1) % 60;
          else y.mins = (x.mins + 1) % (x.maxm + 1);
        end
        if (!adj) y.st = S_P;
      end
    endcase
    return y;
  endfunction

  function automatic logic [19:0] expv(mdl_t x);
    logic ad;
    ad = (x.st == S_A);
    return {4'(x.mins / 10), 4'(x.mins % 10),
            4'(x.secs / 10), 4'(x.secs % 10),
            logic'(x.st == S_R), logic'(x.roll),
            ad & ~sel & c2, ad & sel & c2};
  endfunction

  task automatic chk(input string nm, input logic [19:0] got,
                     input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic check_all(input string nm);
    chk({nm, "/max99"}, got_a, expv(m[0]));
    chk({nm, "/max2"}, got_b, expv(m[1]));
  endtask

  task automatic step();
    bit t1, t2;
    t1 = c1 && !p1;
    t2 = c2 && !p2;
    for (int k = 0; k < 2; k++) m[k] = nxt(m[k], t1, t2);
    p1 = c1;
    p2 = c2;
  endtask

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m[k].mins = 0;
      m[k].secs = 0;
      m[k].st = S_P;
      m[k].roll = 1'b0;
    end
    p1 = 1'b1;
    p2 = 1'b1;
  endtask

  task automatic cyc(input logic a1, input logic a2, input logic ab,
                     input logic aa, input logic as, input string nm);
    @(negedge clk);
    c1 = a1;
    c2 = a2;
    btn = ab;
    adj = aa;
    sel = as;
    @(posedge clk);
    step();
    #1;
    check_all(nm);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    step();
    #1;
    check_all("post_reset");
  endtask

  task automatic do_reset(input logic a1, input logic a2);
    @(negedge clk);
    c1 = a1;
    c2 = a2;
    btn = 1'b0;
    adj = 1'b0;
    sel = 1'b0;
    rst = 1'b1;
    mreset();
    #1;
    check_all("in_reset");
    release_rst();
  endtask

  task automatic adj_to(input int mn, input int sc);
    cyc(0, 0, 0, 1, 0, "adj_enter");
    for (int i = 0; i < mn; i++) begin
      cyc(0, 1, 0, 1, 0, "adj_min_hi");
      cyc(0, 0, 0, 1, 0, "adj_min_lo");
    end
    for (int i = 0; i < sc; i++) begin
      cyc(0, 1, 0, 1, 1, "adj_sec_hi");
      cyc(0, 0, 0, 1, 1, "adj_sec_lo");
    end
    cyc(0, 0, 0, 0, 0, "adj_exit");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m[0].maxm = 99;
    m[1].maxm = 2;
    c1 = 1'b0;
    c2 = 1'b0;
    btn = 1'b0;
    adj = 1'b0;
    sel = 1'b0;
    rst = 1'b1;
    mreset();

    tv[0]  = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 0};
    tv[1]  = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
    tv[2]  = '{1, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    tv[3]  = '{1, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    tv[4]  = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    tv[5]  = '{1, 0, 1, 0, 0, 1, 2, 0, 0, 0};
    tv[6]  = '{0, 0, 0, 0, 0, 1, 2, 0, 0, 0};
    tv[7]  = '{1, 0, 0, 0, 0, 1, 2, 0, 0, 0};
    tv[8]  = '{0, 0, 0, 1, 1, 1, 2, 0, 0, 0};
    tv[9]  = '{0, 1, 0, 1, 1, 1, 3, 0, 0, 1};
    tv[10] = '{0, 1, 0, 1, 0, 1, 3, 0, 1, 0};
    tv[11] = '{0, 0, 0, 1, 0, 1, 3, 0, 0, 0};
    tv[12] = '{0, 1, 0, 1, 0, 2, 3, 0, 1, 0};
    tv[13] = '{1, 0, 0, 1, 0, 2, 3, 0, 0, 0};
    tv[14] = '{0, 0, 0, 0, 0, 2, 3, 0, 0, 0};
    tv[15] = '{0, 0, 1, 0, 0, 2, 3, 1, 0, 0};
    tv[16] = '{1, 0, 0, 1, 0, 2, 3, 0, 0, 0};
    tv[17] = '{1, 0, 0, 0, 0, 2, 3, 0, 0, 0};
    // em holds minutes+1 so that zero-initialised rows are not mistaken
    for (int i = 0; i < 18; i++) tv[i].em = tv[i].em - 1;

    // Reset with CLK_1HZ held high: no tick on release
    do_reset(1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, "hold_high");
    chk("no_tick_after_reset", got_a, 20'h0);

    // Directed table
    for (int i = 0; i < 18; i++) begin
      cyc(tv[i].c1, tv[i].c2, tv[i].btn, tv[i].adj, tv[i].sel, "table");
      chk($sformatf("table_row%0d", i), got_a,
          {4'(tv[i].em / 10), 4'(tv[i].em % 10),
           4'(tv[i].es / 10), 4'(tv[i].es % 10),
           tv[i].er, 1'b0, tv[i].ebm, tv[i].ebs});
    end

    // 61 one-hertz edges from 00:00
    do_reset(0, 0);
    cyc(0, 0, 1, 0, 0, "start");
    for (int i = 0; i < 61; i++) begin
      cyc(1, 0, 0, 0, 0, "count_edge");
      cyc(0, 0, 0, 0, 0, "count_low");
    end
    chk("count_61", got_a, {16'h0101, 4'b1000});

    // Preload 02:59, run one tick: max-2 instance wraps
    do_reset(0, 0);
    adj_to(2, 59);
    cyc(0, 0, 1, 0, 0, "roll_run");
    cyc(1, 0, 0, 0, 0, "roll_tick");
    chk("rollover_wrap", got_b, {16'h0000, 4'b1100});
    chk("no_rollover_max99", got_a, {16'h0300, 4'b1000});
    cyc(0, 0, 0, 0, 0, "roll_after");
    chk("rollover_one_cycle", got_b, {16'h0000, 4'b1000});

    // Seconds adjust 00:58 + 3 -> 00:01, blink follows CLK_2HZ
    do_reset(0, 0);
    cyc(0, 0, 0, 1, 1, "sadj_enter");
    for (int i = 0; i < 58; i++) begin
      cyc(0, 1, 0, 1, 1, "sadj_pre_hi");
      cyc(0, 0, 0, 1, 1, "sadj_pre_lo");
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 1, 1, "sadj_hi");
      chk("blank_sec_hi", got_a[1:0], 20'(2'b01));
      cyc(0, 0, 0, 1, 1, "sadj_lo");
    end
    chk("sadj_result", got_a, {16'h0001, 4'b0000});
    cyc(0, 0, 0, 0, 1, "sadj_exit");
    cyc(0, 1, 0, 0, 1, "sadj_paused");
    chk("paused_no_blank", got_a, {16'h0001, 4'b0000});

    // Pause coincident with tick at 00:09
    do_reset(0, 0);
    cyc(0, 0, 1, 0, 0, "pt_start");
    for (int i = 0; i < 9; i++) begin
      cyc(1, 0, 0, 0, 0, "pt_hi");
      cyc(0, 0, 0, 0, 0, "pt_lo");
    end
    cyc(1, 0, 1, 0, 0, "pt_both");
    chk("pause_with_tick", got_a, {16'h0010, 4'b0000});
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, "pt_lo2");
      cyc(1, 0, 0, 0, 0, "pt_hi2");
    end
    chk("paused_holds", got_a, {16'h0010, 4'b0000});

    // Asynchronous reset at 05:37 while running
    do_reset(0, 0);
    adj_to(5, 30);
    cyc(0, 0, 1, 0, 0, "ar_run");
    for (int i = 0; i < 7; i++) begin
      cyc(1, 0, 0, 0, 0, "ar_hi");
      cyc(0, 0, 0, 0, 0, "ar_lo");
    end
    chk("at_0537", got_a, {16'h0537, 4'b1000});
    @(negedge clk);
    #2;
    rst = 1'b1;
    mreset();
    #1;
    chk("async_reset_a", got_a, 20'h0);
    chk("async_reset_b", got_b, 20'h0);
    release_rst();

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset(c1, c2);
      end else begin
        cyc(($urandom_range(0, 2) == 0) ? ~c1 : c1,
            ($urandom_range(0, 2) == 0) ? ~c2 : c2,
            logic'($urandom_range(0, 7) == 0),
            ($urandom_range(0, 24) == 0) ? ~adj : adj,
            ($urandom_range(0, 5) == 0) ? ~sel : sel,
            "random");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Consumer end of the clock divider's outputs.
- Takes the divider's CLK_1HZ and CLK_2HZ level outputs on the CLK_REF domain and converts their rising edges into single-cycle ticks.
- Keeps an MM:SS BCD stopwatch count with run/pause and a manual adjust mode.
- Drives digit values and blink-blanking flags to the display multiplexer.

Parameters:
- MAX_MIN, 99, highest minutes value (legal 1..99); the count after MAX_MIN:59 is 00:00.

Ports:
- CLK_REF  in  1  system clock; all state updates on its rising edge.
- CLK_RES  in  1  reset, asynchronous, active-high.
- CLK_1HZ  in  1  divider 1 Hz level output, synchronous to CLK_REF; each rising edge is one count tick.
- CLK_2HZ  in  1  divider 2 Hz level output, synchronous to CLK_REF; rising edges are adjust ticks, high level is blink phase.
- BTN_PAUSE  in  1  debounced one-cycle pulse; toggles run/pause.
- ADJ  in  1  level; high selects adjust mode.
- SEL  in  1  adjust field select: 0 = minutes, 1 = seconds.
- MIN_TENS  out  4  BCD minutes tens.
- MIN_ONES  out  4  BCD minutes ones.
- SEC_TENS  out  4  BCD seconds tens (0..5).
- SEC_ONES  out  4  BCD seconds ones.
- RUNNING  out  1  high in RUN state.
- BLANK_MIN  out  1  display should blank the minutes digits.
- BLANK_SEC  out  1  display should blank the seconds digits.
- ROLLOVER  out  1  one-cycle pulse when the count wraps MAX_MIN:59 -> 00:00.

Behaviour:
- Reset: CLK_RES high asynchronously forces:
  - all digits 0, state PAUSED, RUNNING=0, ROLLOVER=0, BLANK_MIN=BLANK_SEC=0;
  - edge-detect history regs to 1, so an input already high at reset release creates no tick.
  - Reset mid-count discards the count with no pulse.
- Edge detect:
  - One history reg per input; tick = input & ~history.
  - Tick is valid in the cycle where CLK_REF first samples the input high.
  - Digits update at that same CLK_REF edge, so they are visible 1 cycle after the input rises.
- States: PAUSED, RUN, ADJUST.
  - PAUSED: BTN_PAUSE -> RUN. ADJ=1 -> ADJUST. Ticks ignored.
  - RUN: BTN_PAUSE -> PAUSED. ADJ=1 -> ADJUST. Each 1 Hz tick increments the count.
  - ADJUST: entered from any state when ADJ=1.
    - On ADJ=0, exit to PAUSED the next cycle.
    - BTN_PAUSE ignored; 1 Hz ticks ignored.
    - Each 2 Hz tick increments only the SEL field.
- Count increment (RUN):
  - SEC_ONES 9 -> 0 with carry into SEC_TENS; SEC_TENS 5 -> 0 with carry into minutes.
  - Minutes increment BCD. At MAX_MIN with seconds 59, all digits go to 0 and ROLLOVER pulses for exactly that one cycle.
- Adjust increment:
  - Seconds field wraps 59 -> 00 without carry.
  - Minutes field wraps MAX_MIN -> 00 without carry.
  - ROLLOVER never asserts in ADJUST.
- Blanking (combinational from state and regs):
  - BLANK_MIN = (state==ADJUST) & ~SEL & CLK_2HZ.
  - BLANK_SEC = (state==ADJUST) & SEL & CLK_2HZ.
  - Both are 0 outside ADJUST.
- Simultaneous events (decisions based on current state):
  - ADJ=1 and a 1 Hz tick in the same RUN cycle: go to ADJUST, tick dropped.
  - BTN_PAUSE and a 1 Hz tick in RUN: tick applied and state -> PAUSED.
  - BTN_PAUSE and a 1 Hz tick in PAUSED: state -> RUN, tick dropped.
  - SEL changing in the same cycle as a 2 Hz tick: the new SEL value selects the field.
- Digits are never outside BCD/legal range; the legal range is checked by assertion in sim.

Test Plan:
- Reset with CLK_1HZ held high, release, no further edges -> digits 00:00, PAUSED, no count change.
- BTN_PAUSE pulse, then 61 CLK_1HZ rising edges -> 01:01, RUNNING=1. Each digit change occurs exactly 1 CLK_REF cycle after the edge.
- MAX_MIN=2, preload via adjust to 02:59, run, 1 tick -> 00:00 and ROLLOVER high for exactly 1 cycle.
- ADJ=1, SEL=1 at 00:58, 3 CLK_2HZ edges -> 00:01 with minutes unchanged. BLANK_SEC follows CLK_2HZ, BLANK_MIN=0. ADJ=0 -> PAUSED.
- In RUN, assert BTN_PAUSE on the same cycle as a tick at 00:09 -> 00:10 and PAUSED. Later ticks do not change the count.
- Assert CLK_RES mid-count at 05:37 asynchronously between CLK_REF edges -> outputs 00:00 and RUNNING=0 immediately, before the next CLK_REF edge.
